// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    DRIVE = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Tear-free multiplexed scan controller for common-anode seven-segment digits.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    in_ready,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg_out,
  output logic                    frame_done
);

  localparam int CW = $clog2(max_of(max_of(DIGIT_CYCLES, GUARD_CYCLES), 2));
  localparam int IW = max_of($clog2(NUM_DIGITS), 1);
  localparam logic [CW-1:0] D_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST   = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_q, pend_word_q;
  logic                    pend_q;
  logic                    advance, wrap, commit, xfer;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic [6:0]              seg_d, dec_seg;
  logic [3:0]              nibble;
  logic                    blank_lead;

  assign in_ready = !pend_q && !rst;
  assign xfer     = in_valid && in_ready;
  assign commit   = pend_q && (!enable || wrap);
  assign nibble   = disp_q[4*idx_q +: 4];

  seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // A digit is a leading zero when it and every more-significant nibble are 0.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_zero[k] = ((disp_q >> (4*k)) == '0);
    end
  end

  assign blank_lead = (idx_q != '0) && lead_zero[idx_q];
`else
  assign blank_lead = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    advance = 1'b0;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = DRIVE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DRIVE: if (cnt_q == D_LAST) begin
          cnt_d = '0;
          if (GUARD_CYCLES == 0) advance = 1'b1;
          else                   state_d = GUARD;
        end
        GUARD: if (cnt_q == G_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
          advance = 1'b1;
        end
        default: state_d = DRIVE;
      endcase
      if (advance) begin
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
  end

  // Outputs follow the current state/index, registered one cycle later.
  always_comb begin
    sel_d = '1;
    seg_d = SEG_BLANK;
    if (enable && state_q == DRIVE) begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = blank_lead ? SEG_BLANK : dec_seg;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DRIVE;
      idx_q       <= '0;
      cnt_q       <= '0;
      disp_q      <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      digit_sel   <= '1;
      seg_out     <= SEG_BLANK;
      frame_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      digit_sel  <= sel_d;
      seg_out    <= seg_d;
      frame_done <= wrap;
      // Commit and transfer are exclusive: one needs pend set, the other clear.
      if (commit) begin
        disp_q <= pend_word_q;
        pend_q <= 1'b0;
      end else if (xfer) begin
        pend_word_q <= in_data;
        pend_q      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: a 4-digit guarded instance and a
// 2-digit no-guard instance, both checked against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int N0 = 4, D0 = 4, G0 = 1;
  localparam int N1 = 2, D1 = 4, G1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0]  in_data1 = '0;

  logic        ready0, fd0, ready1, fd1;
  logic [3:0]  sel0;
  logic [1:0]  sel1;
  logic [6:0]  seg0, seg1;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N0), .DIGIT_CYCLES(D0), .GUARD_CYCLES(G0)) u_dut0 (
    .clk (clk), .rst (rst), .enable (enable), .in_valid (in_valid),
    .in_data (in_data), .in_ready (ready0), .digit_sel (sel0),
    .seg_out (seg0), .frame_done (fd0)
  );

  seg_scan_ctrl #(.NUM_DIGITS(N1), .DIGIT_CYCLES(D1), .GUARD_CYCLES(G1)) u_dut1 (
    .clk (clk), .rst (rst), .enable (enable), .in_valid (in_valid),
    .in_data (in_data1), .in_ready (ready1), .digit_sel (sel1),
    .seg_out (seg1), .frame_done (fd1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position t within the frame, displayed/pending words, pend flag.
  int          t     [2];
  logic [31:0] disp  [2];
  logic [31:0] pword [2];
  bit          pend  [2];
  logic [7:0]  e_sel [2];
  logic [6:0]  e_seg [2];
  bit          e_fd  [2];

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  task automatic model_step(input int i, input int n, input int d, input int g,
                            input bit r, input bit e, input bit v, input logic [31:0] data);
    int per   = d + g;
    int frame = n * per;
    int dig   = t[i] / per;
    bit guard = (t[i] % per) >= d;
    bit boundary = (t[i] == frame - 1);
    bit commit;
    e_sel[i] = 8'hFF;
    e_seg[i] = 7'h7F;
    e_fd[i]  = 1'b0;
    if (!r && e) begin
      e_fd[i] = boundary;
      if (!guard) begin
        e_sel[i] = ~(8'd1 << dig);
        e_seg[i] = seg_of(disp[i][4*dig +: 4]);
`ifdef SEG_SCAN_LZB_EN
        if (dig > 0 && (disp[i] >> (4*dig)) == 0) e_seg[i] = 7'h7F;
`endif
      end
    end
    if (r) begin
      t[i] = 0; disp[i] = 0; pword[i] = 0; pend[i] = 1'b0;
    end else begin
      commit = pend[i] && (!e || boundary);
      t[i] = e ? (t[i] + 1) % frame : 0;
      if (commit) begin
        disp[i] = pword[i];
        pend[i] = 1'b0;
      end else if (v && !pend[i]) begin
        pword[i] = data;
        pend[i]  = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [15:0] d);
    @(negedge clk);
    rst = r; enable = e; in_valid = v; in_data = d; in_data1 = d[7:0];
    #1;
    check("ready0", ready0, !pend[0] && !r);
    check("ready1", ready1, !pend[1] && !r);
    model_step(0, N0, D0, G0, r, e, v, {16'h0, d});
    model_step(1, N1, D1, G1, r, e, v, {24'h0, d[7:0]});
    @(posedge clk);
    #1;
    check("sel0", sel0, e_sel[0][3:0]);
    check("seg0", seg0, e_seg[0]);
    check("fd0",  fd0,  e_fd[0]);
    check("sel1", sel1, e_sel[1][1:0]);
    check("seg1", seg1, e_seg[1]);
    check("fd1",  fd1,  e_fd[1]);
  endtask

  // Hold in_valid with one word until the 4-digit instance takes it.
  task automatic send_hold(input logic [15:0] d);
    bit taken = 1'b0;
    for (int k = 0; k < 200 && !taken; k++) begin
      taken = !pend[0];
      step(0, 1, 1, d);
    end
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(0, 1, 0, 16'h0);
  endtask

  initial begin
    bit en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; disp[i] = 0; pword[i] = 0; pend[i] = 1'b0;
    end

    repeat (3) step(1, 1, 0, 16'h0);
    idle(25);
    step(0, 1, 1, 16'h1234);
    idle(45);

    send_hold(16'hABCD);
    send_hold(16'hEF01);
    idle(50);

    for (int k = 0; k < 40 && t[0] != 0; k++) step(0, 1, 0, 16'h0);
    send_hold(16'h0009);
    for (int k = 0; k < 40 && t[0] / (D0 + G0) != 2; k++) step(0, 1, 0, 16'h0);
    repeat (3) step(0, 0, 0, 16'h0);
    idle(12);

    send_hold(16'h0050);
    idle(45);
    send_hold(16'h0000);
    idle(45);

    step(0, 1, 1, 16'h4321);
    idle(7);
    repeat (2) step(1, 1, 0, 16'h0);
    idle(10);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      step($urandom_range(0, 299) == 0, en, $urandom_range(0, 3) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
